stim_seq_ctrl: RTL
==================

Name: stim_seq_ctrl

Overview:
Synthesizable sequencer that replaces hand-written post-reset stimulus blocks. It drives the two stimulus lines a and b in one of four selectable timed patterns, either launched automatically after reset release or on a start pulse. It sits between the bench control logic (select/start) and the DUT stimulus inputs, and reports busy/done/error status for scoreboarding.

Parameters:
SHORT_DLY, 2, cycles between a-update and b-update for patterns 0-2 (must be >= 1)
LONG_DLY, 4, cycles between a-update and b-update for pattern 3 (must be >= 1)
CNT_W, 8, delay counter width; both delays must be < 2**CNT_W
AUTO_START, 1, when 1 one sequence launches automatically after reset release

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, active-high, synchronous
select  input  4  pattern number, sampled only at launch
start  input  1  launch request, single-cycle pulse, accepted only in IDLE
a  output  1  stimulus line a (registered)
b  output  1  stimulus line b (registered)
busy  output  1  high while a sequence is between its a-update and b-update
done  output  1  1-cycle pulse in the cycle b takes its final value
err  output  1  1-cycle pulse: illegal select (4-15) at launch
drop  output  1  1-cycle pulse: start seen while not IDLE (request discarded)
test_id  output  2  pattern number of last legal launch
seq_cnt  output  8  count of completed sequences, wraps 255->0

Behaviour:
- Reset (rst=1 at an edge): a=0, b=0, busy=0, done=0, err=0, drop=0, test_id=0, seq_cnt=0, delay counter=0, state=IDLE, auto_pend=AUTO_START. Reset mid-sequence aborts it; no done is issued.
- States: IDLE, WAIT.
- Launch condition: state==IDLE and (start or auto_pend). auto_pend clears on the launch edge, whether or not the select is legal. start and auto_pend together produce a single launch.
- Launch edge N (select sampled at N):
  - select 0: a<=1, b target 1, delay SHORT_DLY.
  - select 1: a<=0, b target 1, delay SHORT_DLY.
  - select 2: a<=1, b target 0, delay SHORT_DLY.
  - select 3: a<=1, b target 1, delay LONG_DLY.
  - Legal select: test_id<=select[1:0]; counter<=delay-1; state<=WAIT; busy<=1.
  - select 4-15: err<=1 for one cycle; a, b, test_id unchanged; state stays IDLE.
- WAIT at edge: if counter==0 then b<=target, done<=1, busy<=0, seq_cnt<=seq_cnt+1, state<=IDLE; else counter<=counter-1.
- Timing for delay D: a valid after edge N, b valid after edge N+D, done high for the single cycle following edge N+D. busy is high after edges N..N+D-1. A new launch is possible at edge N+D+1.
- b holds its previous value between sequences. The target is loaded into b even when it equals the current value.
- start while in WAIT: drop pulses for 1 cycle; the running sequence is unaffected; the request is not queued.
- start on the same edge the sequence completes (state still WAIT): dropped.
- With AUTO_START=0, no activity occurs until start.
- a, b and the status outputs are fully registered; no combinational path from inputs to outputs.

Test Plan:
- Auto launch, select=0, SHORT_DLY=2: release rst at edge R -> a=1 after R+1, b=1 after R+3, done pulse 1 cycle, seq_cnt=1, test_id=0.
- start with select=1 after a=1,b=1 -> a=0 after the next edge; b stays 1 and is re-written to 1 after edge +2; done once; seq_cnt increments.
- select=3, start -> busy high 4 cycles, b updates exactly 4 edges after a, test_id=3.
- select=2, start -> a=1, b=0 after 2 edges. Then select=9, start -> err pulse only; a, b, test_id unchanged; busy stays 0.
- start pulsed on every cycle during a select=3 sequence -> drop pulses on each of those cycles; sequence completes unchanged; next start after done is accepted.
- rst asserted one cycle into WAIT -> all outputs 0 after the next edge, no done; after rst release, auto launch re-runs per the current select.

Source files
------------

// File: rtl/stim_seq_ctrl.sv
// Timed two-line stimulus sequencer: drives a, then b after a per-pattern delay.
// Launches on a start pulse or once automatically after reset; reports busy/done/err/drop.
module stim_seq_ctrl #(
    parameter int unsigned SHORT_DLY  = 2,
    parameter int unsigned LONG_DLY   = 4,
    parameter int unsigned CNT_W      = 8,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] select,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       drop,
    output logic [1:0] test_id,
    output logic [7:0] seq_cnt
);

    localparam int unsigned SEQ_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               auto_pend, auto_pend_nxt;
    logic               b_tgt, b_tgt_nxt;
    logic               a_nxt, b_nxt, busy_nxt, done_nxt, err_nxt, drop_nxt;
    logic [1:0]         test_id_nxt;
    logic [SEQ_W-1:0]   seq_cnt_nxt;
    logic               launch_c;

    assign launch_c = (state == IDLE) && (start || auto_pend);

    // State and all outputs registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            auto_pend <= AUTO_START;
            b_tgt     <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            drop      <= 1'b0;
            test_id   <= 2'd0;
            seq_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            auto_pend <= auto_pend_nxt;
            b_tgt     <= b_tgt_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            drop      <= drop_nxt;
            test_id   <= test_id_nxt;
            seq_cnt   <= seq_cnt_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        auto_pend_nxt = auto_pend;
        b_tgt_nxt     = b_tgt;
        a_nxt         = a;
        b_nxt         = b;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        drop_nxt      = 1'b0;
        test_id_nxt   = test_id;
        seq_cnt_nxt   = seq_cnt;

        case (state)
            IDLE: begin
                if (launch_c) begin
                    auto_pend_nxt = 1'b0;
                    if (select[3:2] != 2'b00) begin
                        err_nxt = 1'b1;
                    end else begin
                        test_id_nxt = select[1:0];
                        state_nxt   = WAIT;
                        busy_nxt    = 1'b1;
                        case (select[1:0])
                            2'd0: begin
                                a_nxt     = 1'b1;
                                b_tgt_nxt = 1'b1;
                                cnt_nxt   = CNT_W'(SHORT_DLY - 1);
                            end
                            2'd1: begin
                                a_nxt     = 1'b0;
                                b_tgt_nxt = 1'b1;
                                cnt_nxt   = CNT_W'(SHORT_DLY - 1);
                            end
                            2'd2: begin
                                a_nxt     = 1'b1;
                                b_tgt_nxt = 1'b0;
                                cnt_nxt   = CNT_W'(SHORT_DLY - 1);
                            end
                            default: begin
                                a_nxt     = 1'b1;
                                b_tgt_nxt = 1'b1;
                                cnt_nxt   = CNT_W'(LONG_DLY - 1);
                            end
                        endcase
                    end
                end
            end
            WAIT: begin
                // Requests during a running sequence are discarded, not queued
                drop_nxt = start;
                if (cnt == '0) begin
                    b_nxt       = b_tgt;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    seq_cnt_nxt = seq_cnt + SEQ_W'(1);
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
